// File: rtl/branch_pred_table_pkg.sv
// Shared types and encodings for the branch prediction table.
// Entries pair a direct-mapped target with a 2-bit direction counter.
package bp_pkg;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // The tag field is sized for the narrowest index so one struct fits every IDX_W.
    localparam int unsigned MAX_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           cnt;
    } bp_entry_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } bp_state_e;

    function automatic logic cnt_taken(input logic [1:0] cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/branch_pred_table_sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       up,
    output logic [1:0] nxt
);

    // Step towards strongly taken or strongly not-taken, holding at the ends.
    always_comb begin
        nxt = cnt;
        if (up) begin
            if (cnt != ST) nxt = cnt + 2'd1;
            else           nxt = ST;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
            else            nxt = SNT;
        end
    end

endmodule

// File: rtl/branch_pred_table.sv
// Direct-mapped branch target table with per-entry 2-bit direction counters.
// Combinational lookup, clocked update, and an init sweep that clears valid bits.
module branch_pred_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inv_all_i,
    output logic             ready_o,
    input  logic [31:0]      lk_pc_i,
    output logic             lk_hit_o,
    output logic             lk_taken_o,
    output logic [31:0]      lk_target_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_mispred_i,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int DEPTH = 2 ** IDX_W;

    logic             valid_r  [DEPTH];
    logic [TAG_W-1:0] tag_r    [DEPTH];
    logic [31:0]      target_r [DEPTH];
    logic [1:0]       cnt_r    [DEPTH];

    bp_state_e        state_r, state_nxt_s;
    logic [IDX_W-1:0] init_idx_r, init_idx_nxt_s;
    logic             ready_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    logic [IDX_W-1:0] lk_idx_s, upd_idx_s;
    logic [TAG_W-1:0] lk_tag_s, upd_tag_s;
    bp_entry_t        lk_entry_s;
    logic             lk_hit_s, lk_taken_s;
    logic [31:0]      lk_target_s;
    logic             upd_en_s, upd_hit_s;
    logic [1:0]       cnt_step_s, cnt_wdata_s;
    logic             wr_valid_s, wr_tag_s, wr_target_s, wr_cnt_s;
    logic             unused_s;

    assign lk_idx_s  = lk_pc_i[IDX_W+1:2];
    assign lk_tag_s  = lk_pc_i[31:IDX_W+2];
    assign upd_idx_s = upd_pc_i[IDX_W+1:2];
    assign upd_tag_s = upd_pc_i[31:IDX_W+2];
    assign unused_s  = ^{lk_pc_i[1:0], upd_pc_i[1:0], lk_entry_s.cnt[0]};

    // Lookup reads the pre-edge table contents with no bypass from the update port.
    always_comb begin
        lk_entry_s        = '0;
        lk_entry_s.valid  = valid_r[lk_idx_s];
        lk_entry_s.tag    = MAX_TAG_W'(tag_r[lk_idx_s]);
        lk_entry_s.target = target_r[lk_idx_s];
        lk_entry_s.cnt    = cnt_r[lk_idx_s];
        lk_hit_s = ready_r & lk_entry_s.valid & (lk_entry_s.tag == MAX_TAG_W'(lk_tag_s));
        if (lk_hit_s) begin
            lk_taken_s  = cnt_taken(lk_entry_s.cnt);
            lk_target_s = lk_entry_s.target;
        end else begin
            lk_taken_s  = 1'b0;
            lk_target_s = 32'h0000_0000;
        end
    end

    // An invalidate in the same cycle pre-empts any update.
    assign upd_en_s  = rst_ni & upd_valid_i & ready_r & ~inv_all_i;
    assign upd_hit_s = valid_r[upd_idx_s] & (tag_r[upd_idx_s] == upd_tag_s);

    sat_counter2 u_sat_counter2 (
        .cnt (cnt_r[upd_idx_s]),
        .up  (upd_taken_i),
        .nxt (cnt_step_s)
    );

    // Decide which fields of the indexed entry the resolved branch rewrites.
    always_comb begin
        wr_valid_s  = 1'b0;
        wr_tag_s    = 1'b0;
        wr_target_s = 1'b0;
        wr_cnt_s    = 1'b0;
        cnt_wdata_s = cnt_step_s;
        if (upd_en_s && upd_hit_s) begin
            wr_cnt_s    = 1'b1;
            wr_target_s = upd_taken_i;
        end else if (upd_en_s && upd_taken_i) begin
            wr_valid_s  = 1'b1;
            wr_tag_s    = 1'b1;
            wr_target_s = 1'b1;
            wr_cnt_s    = 1'b1;
            cnt_wdata_s = WT;
        end else begin
            wr_cnt_s    = 1'b0;
        end
    end

    // Payload arrays carry no reset so they can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (wr_tag_s)    tag_r[upd_idx_s]    <= upd_tag_s;
        if (wr_target_s) target_r[upd_idx_s] <= upd_target_i;
        if (wr_cnt_s)    cnt_r[upd_idx_s]    <= cnt_wdata_s;
    end

    // Valid bits are cleared only by the sweep, one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (state_r == INIT)  valid_r[init_idx_r] <= 1'b0;
        else if (wr_valid_s)  valid_r[upd_idx_s]  <= 1'b1;
    end

    // Sweep sequencing: restart on invalidate, leave after the last index.
    always_comb begin
        state_nxt_s    = state_r;
        init_idx_nxt_s = init_idx_r;
        case (state_r)
            INIT: begin
                if (inv_all_i) begin
                    init_idx_nxt_s = '0;
                end else if (init_idx_r == {IDX_W{1'b1}}) begin
                    state_nxt_s    = READY;
                    init_idx_nxt_s = '0;
                end else begin
                    init_idx_nxt_s = init_idx_r + IDX_W'(1'b1);
                end
            end
            READY: begin
                if (inv_all_i) begin
                    state_nxt_s    = INIT;
                    init_idx_nxt_s = '0;
                end else begin
                    state_nxt_s    = READY;
                end
            end
            default: begin
                state_nxt_s    = INIT;
                init_idx_nxt_s = '0;
            end
        endcase
    end

    // Control state and the misprediction counter, which survives invalidates.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r       <= INIT;
            init_idx_r    <= '0;
            ready_r       <= 1'b0;
            mispred_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            init_idx_r <= init_idx_nxt_s;
            ready_r    <= (state_nxt_s == READY);
            if (upd_valid_i && upd_mispred_i && ready_r && (mispred_cnt_r != {CNT_W{1'b1}}))
                mispred_cnt_r <= mispred_cnt_r + CNT_W'(1'b1);
            else
                mispred_cnt_r <= mispred_cnt_r;
        end
    end

    assign ready_o       = ready_r;
    assign lk_hit_o      = lk_hit_s;
    assign lk_taken_o    = lk_taken_s;
    assign lk_target_o   = lk_target_s;
    assign mispred_cnt_o = mispred_cnt_r;

endmodule
